stream_fifo: RTL

- Parametrised valid/ready buffering stage that generalises the single/double-slot pipeline register to an arbitrary-depth circular FIFO.
- Provides an optional fall-through (zero-latency) mode, a synchronous flush and an occupancy output.
- Sits between any two valid/ready stream endpoints to break timing paths, absorb bursts or decouple producer/consumer rates.

---
 rtl/stream_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised valid/ready circular FIFO with optional
// fall-through (zero-latency when empty), synchronous flush and an
// occupancy count. Pointers wrap explicitly so DEPTH need not be 2^n.
module stream_fifo #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter type         TYPE         = logic [DATA_WIDTH-1:0],
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  TYPE                        w_data,
  output logic                       r_valid,
  input  logic                       r_ready,
  output TYPE                        r_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  // A single-entry FIFO still needs a one-bit pointer.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  TYPE              mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic empty_s, full_s;
  logic w_hs_s, r_hs_s, bypass_s, store_s, pop_s;

  // Advance a pointer, wrapping from the last entry back to zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Stream-side flags and payload; ready never looks at r_ready.
  always_comb begin
    empty_s = (level_q == '0);
    full_s  = (level_q == LVL_FULL);
    w_ready = !full_s && !flush;
    if (FALL_THROUGH) begin
      r_valid = (!empty_s || w_valid) && !flush;
      if (empty_s) begin
        r_data = w_data;
      end else begin
        r_data = mem_q[rd_ptr_q];
      end
    end else begin
      r_valid = !empty_s && !flush;
      r_data  = mem_q[rd_ptr_q];
    end
  end

  // Classify this cycle's handshakes: bypass, stored write, storage read.
  always_comb begin
    w_hs_s   = w_valid && w_ready;
    r_hs_s   = r_valid && r_ready;
    bypass_s = FALL_THROUGH && empty_s && w_hs_s && r_hs_s;
    store_s  = w_hs_s && !bypass_s;
    pop_s    = r_hs_s && !empty_s;
  end

  // Next-state pointers and occupancy; flush wins over everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (store_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({store_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload storage; left unreset since r_data is ignored while invalid.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

  assign level = level_q;

endmodule
